// File: rtl/mips_run_pkg.sv
// Shared types for the mips run controller: FSM states, run status
// codes and the PC signature step function.
package mips_run_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RST  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] ST_NONE    = 2'd0;
    localparam logic [1:0] ST_HALT    = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    // Rotate left by one, then fold in the retired PC.
    function automatic logic [31:0] sig_step(
        input logic [31:0] sig,
        input logic [31:0] pc
    );
        return {sig[30:0], sig[31]} ^ pc;
    endfunction

endpackage

// File: rtl/mips_halt_det.sv
// Self-loop halt detector: flags the retire that completes HALT_REPEAT
// consecutive retires at one PC.
// Ports: clk, reset (async, active-low), clear (sync), retire, pc in;
//        halt out (combinational pulse on the completing retire).
module mips_halt_det #(
    parameter int HALT_REPEAT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        retire,
    input  logic [31:0] pc,
    output logic        halt
);

    localparam int RW = $clog2(HALT_REPEAT + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(HALT_REPEAT - 1);
    localparam logic [RW-1:0] REP_MAX  = RW'(HALT_REPEAT);
    localparam logic [RW-1:0] REP_ONE  = RW'(1);

    logic [31:0]   last_pc;
    logic [RW-1:0] rep;
    logic          match;

    // rep == 0 means no retire seen since clear, so last_pc is invalid.
    assign match = (rep != '0) && (pc == last_pc);
    assign halt  = retire && match && (rep == REP_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_pc <= '0;
            rep     <= '0;
        end else if (clear) begin
            last_pc <= '0;
            rep     <= '0;
        end else if (retire) begin
            last_pc <= pc;
            if (!match)
                rep <= REP_ONE;
            else if (rep != REP_MAX)
                rep <= rep + REP_ONE;
        end
    end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for the single-cycle mips core: sequences core reset,
// counts run cycles and retires, ends each run on halt or timeout and
// repeats for NUM_RUNS runs per start.
// Ports: clk, reset (async, active-low), start, retire, retire_pc in;
//        cpu_reset, running, done, status, run_idx, cycle_cnt,
//        instr_cnt, sig_out out.
// Optional: define MIPS_RUN_SIG_EN to build the PC signature register;
//        otherwise sig_out is tied to zero.
module mips_run_ctrl
    import mips_run_pkg::*;
#(
    parameter int RST_CYCLES  = 1,
    parameter int MAX_CYCLES  = 500,
    parameter int NUM_RUNS    = 1,
    parameter int HALT_REPEAT = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             retire,
    input  logic [31:0]      retire_pc,
    output logic             cpu_reset,
    output logic             running,
    output logic             done,
    output logic [1:0]       status,
    output logic [7:0]       run_idx,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [31:0]      sig_out
);

    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RCW-1:0]   RST_LAST = RCW'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [7:0]       LAST_RUN = 8'(NUM_RUNS - 1);

    state_t         state;
    state_t         next_state;
    logic [RCW-1:0] rst_cnt;

    logic in_rst;
    logic in_run;
    logic rtr;
    logic halt;
    logic tout;
    logic fin;
    logic last;
    logic rst_end;
    logic launch;

    logic cpu_reset_d;
    logic running_d;
    logic done_d;

    assign in_rst  = (state == RST);
    assign in_run  = (state == RUN);
    assign rtr     = retire && in_run;
    assign tout    = in_run && (cycle_cnt == CYC_LAST);
    assign fin     = in_run && (halt || tout);
    assign last    = (run_idx >= LAST_RUN);
    assign rst_end = in_rst && (rst_cnt == RST_LAST);
    assign launch  = start && ((state == IDLE) || (state == DONE));

    mips_halt_det #(
        .HALT_REPEAT (HALT_REPEAT)
    ) u_halt (
        .clk    (clk),
        .reset  (reset),
        .clear  (in_rst),
        .retire (rtr),
        .pc     (retire_pc),
        .halt   (halt)
    );

    // State register; the FSM outputs are registered here too so that
    // they switch together with the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cpu_reset <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= next_state;
            cpu_reset <= cpu_reset_d;
            running   <= running_d;
            done      <= done_d;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (start)   next_state = RST;
            RST:  if (rst_end) next_state = RUN;
            RUN:  if (fin)     next_state = last ? DONE : RST;
            DONE: if (start)   next_state = RST;
            default:           next_state = IDLE;
        endcase
    end

    // Outputs decoded from the next state, so they are valid on the
    // first cycle the FSM spends in that state.
    always_comb begin
        cpu_reset_d = 1'b1;
        running_d   = 1'b0;
        done_d      = 1'b0;
        unique case (next_state)
            RUN: begin
                cpu_reset_d = 1'b0;
                running_d   = 1'b1;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rst_cnt <= '0;
        else if (in_rst && !rst_end)
            rst_cnt <= rst_cnt + RCW'(1);
        else
            rst_cnt <= '0;
    end

    // The ending cycle does not advance cycle_cnt, so a timeout leaves
    // it at MAX_CYCLES-1; the ending retire itself is still counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else if (in_rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (in_run && !fin && (cycle_cnt != '1))
                cycle_cnt <= cycle_cnt + CNT_ONE;
            if (rtr && (instr_cnt != '1))
                instr_cnt <= instr_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status  <= ST_NONE;
            run_idx <= '0;
        end else if (launch) begin
            status  <= ST_NONE;
            run_idx <= '0;
        end else if (fin) begin
            status <= halt ? ST_HALT : ST_TIMEOUT;
            if (!last)
                run_idx <= run_idx + 8'd1;
        end
    end

`ifdef MIPS_RUN_SIG_EN
    logic [31:0] sig;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sig <= '0;
        else if (in_rst)
            sig <= '0;
        else if (rtr)
            sig <= sig_step(sig, retire_pc);
    end

    assign sig_out = sig;
`else
    assign sig_out = '0;
`endif

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl: per-cycle vector table on a
// single-run instance plus hand sequences for multi-run and abort.
module tb_mips_run_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        retire = 1'b0;
    logic [31:0] retire_pc = '0;

    logic        cpu_reset_a, running_a, done_a;
    logic [1:0]  status_a;
    logic [7:0]  run_idx_a;
    logic [31:0] cyc_a, instr_a, sig_a;

    logic        cpu_reset_b, running_b, done_b;
    logic [1:0]  status_b;
    logic [7:0]  run_idx_b;
    logic [31:0] cyc_b, instr_b, sig_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mips_run_ctrl #(
        .RST_CYCLES(1), .MAX_CYCLES(10), .NUM_RUNS(1),
        .HALT_REPEAT(4), .CNT_W(32)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .retire(retire), .retire_pc(retire_pc),
        .cpu_reset(cpu_reset_a), .running(running_a), .done(done_a),
        .status(status_a), .run_idx(run_idx_a),
        .cycle_cnt(cyc_a), .instr_cnt(instr_a), .sig_out(sig_a)
    );

    mips_run_ctrl #(
        .RST_CYCLES(2), .MAX_CYCLES(500), .NUM_RUNS(3),
        .HALT_REPEAT(4), .CNT_W(32)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .retire(retire), .retire_pc(retire_pc),
        .cpu_reset(cpu_reset_b), .running(running_b), .done(done_b),
        .status(status_b), .run_idx(run_idx_b),
        .cycle_cnt(cyc_b), .instr_cnt(instr_b), .sig_out(sig_b)
    );

    typedef struct {
        logic        start;
        logic        retire;
        logic [31:0] pc;
        logic        cpu_reset;
        logic        running;
        logic        done;
        logic [1:0]  status;
        logic        chk_cnt;
        logic [31:0] cyc;
        logic [31:0] instr;
        logic        chk_sig;
        logic [31:0] sig;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(
        input logic st, input logic rt, input logic [31:0] pc,
        input logic cr, input logic rn, input logic dn,
        input logic [1:0] stat, input logic cc,
        input logic [31:0] cyc, input logic [31:0] ins,
        input logic cs, input logic [31:0] sig
    );
        vec_t v;
        v.start = st; v.retire = rt; v.pc = pc;
        v.cpu_reset = cr; v.running = rn; v.done = dn;
        v.status = stat; v.chk_cnt = cc; v.cyc = cyc; v.instr = ins;
        v.chk_sig = cs; v.sig = sig;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sig_exp(input logic [31:0] v);
`ifdef MIPS_RUN_SIG_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench watchdog");
    end

    initial begin
        int n;
        // ---- table: halt run, timeout run, halt on timeout cycle ----
        add(1,0,0,           1,0,0,2'd0, 1,0,0, 0,0);
        add(0,0,0,           0,1,0,2'd0, 1,0,0, 1,0);
        add(0,1,32'h3000,    0,1,0,2'd0, 1,1,1, 1,32'h3000);
        add(0,1,32'h3004,    0,1,0,2'd0, 1,2,2, 1,32'h5004);
        add(0,1,32'h3008,    0,1,0,2'd0, 1,3,3, 0,0);
        add(0,1,32'h300c,    0,1,0,2'd0, 1,4,4, 0,0);
        add(0,1,32'h300c,    0,1,0,2'd0, 1,5,5, 0,0);
        add(0,1,32'h300c,    0,1,0,2'd0, 1,6,6, 0,0);
        add(0,1,32'h300c,    1,0,1,2'd1, 1,6,7, 0,0);
        add(0,1,32'h3010,    1,0,1,2'd1, 1,6,7, 0,0);
        add(1,0,0,           1,0,0,2'd0, 0,0,0, 0,0);
        add(0,0,0,           0,1,0,2'd0, 1,0,0, 1,0);
        for (int i = 1; i <= 9; i++)
            add(i == 5, 0, 0, 0,1,0,2'd0, 1,i,0, 0,0);
        add(0,0,0,           1,0,1,2'd2, 1,9,0, 0,0);
        add(0,0,0,           1,0,1,2'd2, 1,9,0, 0,0);
        add(1,0,0,           1,0,0,2'd0, 0,0,0, 0,0);
        add(0,0,0,           0,1,0,2'd0, 1,0,0, 1,0);
        for (int i = 1; i <= 6; i++)
            add(0,0,0,       0,1,0,2'd0, 1,i,0, 0,0);
        add(0,1,32'h100,     0,1,0,2'd0, 1,7,1, 0,0);
        add(0,1,32'h100,     0,1,0,2'd0, 1,8,2, 0,0);
        add(0,1,32'h100,     0,1,0,2'd0, 1,9,3, 0,0);
        add(0,1,32'h100,     1,0,1,2'd1, 1,9,4, 0,0);

        // ---- reset state ----
        repeat (2) tick();
        chk("rst cpu_reset", 32'(cpu_reset_a), 1);
        chk("rst running", 32'(running_a), 0);
        chk("rst done", 32'(done_a), 0);
        chk("rst status", 32'(status_a), 0);
        chk("rst run_idx", 32'(run_idx_a), 0);
        chk("rst cycle", cyc_a, 0);
        chk("rst instr", instr_a, 0);
        chk("rst sig", sig_a, 0);
        reset = 1'b1;
        repeat (2) tick();
        chk("idle cpu_reset", 32'(cpu_reset_a), 1);
        chk("idle running", 32'(running_a), 0);

        // ---- table replay on dut_a ----
        foreach (tbl[k]) begin
            start_a   = tbl[k].start;
            retire    = tbl[k].retire;
            retire_pc = tbl[k].pc;
            tick();
            chk($sformatf("v%0d cpu_reset", k), 32'(cpu_reset_a),
                32'(tbl[k].cpu_reset));
            chk($sformatf("v%0d running", k), 32'(running_a),
                32'(tbl[k].running));
            chk($sformatf("v%0d done", k), 32'(done_a),
                32'(tbl[k].done));
            chk($sformatf("v%0d status", k), 32'(status_a),
                32'(tbl[k].status));
            chk($sformatf("v%0d run_idx", k), 32'(run_idx_a), 0);
            if (tbl[k].chk_cnt) begin
                chk($sformatf("v%0d cycle", k), cyc_a, tbl[k].cyc);
                chk($sformatf("v%0d instr", k), instr_a, tbl[k].instr);
            end
            if (tbl[k].chk_sig)
                chk($sformatf("v%0d sig", k), sig_a, sig_exp(tbl[k].sig));
        end
        start_a = 1'b0;
        retire  = 1'b0;

        // ---- three back-to-back runs on dut_b ----
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int r = 0; r < 3; r++) begin
            chk($sformatf("b%0d run_idx", r), 32'(run_idx_b), r);
            chk($sformatf("b%0d done early", r), 32'(done_b), 0);
            n = 0;
            while (cpu_reset_b && n < 20) begin
                tick();
                n++;
            end
            chk($sformatf("b%0d rst len", r), n, 2);
            chk($sformatf("b%0d running", r), 32'(running_b), 1);
            chk($sformatf("b%0d cyc clr", r), cyc_b, 0);
            chk($sformatf("b%0d instr clr", r), instr_b, 0);
            for (int j = 0; j < 4; j++) begin
                if (r == 1 && j == 2) begin
                    retire = 1'b0;
                    tick();
                end
                retire    = 1'b1;
                retire_pc = 32'h400;
                tick();
            end
            retire = 1'b0;
            chk($sformatf("b%0d status", r), 32'(status_b), 1);
            chk($sformatf("b%0d instr", r), instr_b, 4);
            chk($sformatf("b%0d done", r), 32'(done_b), (r == 2) ? 1 : 0);
            chk($sformatf("b%0d cpu_reset", r), 32'(cpu_reset_b), 1);
        end
        chk("b final run_idx", 32'(run_idx_b), 2);

        // ---- asynchronous abort mid-run on dut_a ----
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        chk("ab running", 32'(running_a), 1);
        for (int j = 0; j < 5; j++) begin
            retire    = 1'b1;
            retire_pc = 32'h200 + 32'(4 * j);
            tick();
        end
        retire = 1'b0;
        chk("ab instr", instr_a, 5);
        #2 reset = 1'b0;
        #1;
        chk("ab cpu_reset", 32'(cpu_reset_a), 1);
        chk("ab running0", 32'(running_a), 0);
        chk("ab instr0", instr_a, 0);
        chk("ab cycle0", cyc_a, 0);
        chk("ab status0", 32'(status_a), 0);
        chk("ab sig0", sig_a, 0);
        #3 reset = 1'b1;
        repeat (3) tick();
        chk("ab stay idle", 32'(cpu_reset_a), 1);
        chk("ab no run", 32'(running_a), 0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        chk("ab resume", 32'(running_a), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
- Synthesizable run controller that drives the single-cycle `mips` core for simulation and board bring-up.
- Sequences the core's reset, counts cycles and retired instructions, and detects program end (a self-loop halt) or a timeout.
- Supports several back-to-back runs, each re-resetting the core.
- Sits between the top-level clock/reset and the core's active-high `reset` input.

Parameters:
- RST_CYCLES, 1, cycles `cpu_reset` is held high at the start of each run (must be ≥1).
- MAX_CYCLES, 500, run-cycle limit before timeout (must be ≥1).
- NUM_RUNS, 1, consecutive runs per start (must be ≥1).
- HALT_REPEAT, 4, consecutive retires at an identical PC that declare a halt (must be ≥2).
- CNT_W, 32, width of the cycle and instruction counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low controller reset.
- start  in  1  one-cycle pulse that begins a run sequence.
- retire  in  1  core retired one instruction this cycle.
- retire_pc  in  32  PC of the retired instruction.
- cpu_reset  out  1  active-high reset to the core.
- running  out  1  high while in RUN.
- done  out  1  all runs finished; held until the next start.
- status  out  2  result of the last completed run: 0 none, 1 halt, 2 timeout.
- run_idx  out  8  index of the current or last run.
- cycle_cnt  out  CNT_W  cycles spent in RUN for the current run.
- instr_cnt  out  CNT_W  retires counted in the current run.
- sig_out  out  32  PC signature (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - cpu_reset=1.
  - running=0, done=0, status=0, run_idx=0.
  - cycle_cnt=0, instr_cnt=0, sig_out=0.
- FSM states are IDLE, RST, RUN, DONE. cpu_reset=1 in every state except RUN.
- IDLE:
  - start=1 → RST.
  - run_idx=0, status=0.
- RST:
  - Counts RST_CYCLES cycles.
  - Clears cycle_cnt, instr_cnt, the halt detector and the signature.
  - Then → RUN.
- RUN:
  - cpu_reset=0 and running=1, registered, so they take effect the first cycle in RUN.
  - cycle_cnt increments every RUN cycle and saturates at all-ones.
  - instr_cnt increments on each retire and saturates.
- Halt:
  - Triggered when retire=1 and retire_pc equals the previous retired PC for HALT_REPEAT consecutive retires.
  - A retire at a different PC resets the repeat count to 1.
  - Cycles without retire leave the count unchanged.
- Timeout: triggered on the cycle when cycle_cnt == MAX_CYCLES-1, i.e. after MAX_CYCLES RUN cycles.
- Halt and timeout in the same cycle: halt wins, status=1.
- On a halt or timeout:
  - status is latched and the counters freeze, holding their final values until the next RST.
  - If run_idx < NUM_RUNS-1: run_idx increments and the FSM goes to RST.
  - Otherwise the FSM goes to DONE.
- DONE:
  - done=1.
  - start=1 → RST with run_idx=0, status=0, done cleared.
- start is ignored in RST and RUN.
- retire is ignored outside RUN.
- reset asserted mid-run aborts immediately to IDLE; no partial status is kept.

Optional Feature:
- Macro: MIPS_RUN_SIG_EN.
- When defined:
  - On each counted retire: sig_out ← {sig_out[30:0], sig_out[31]} ^ retire_pc.
  - sig_out is cleared in RST and frozen after the run ends.
- When undefined: sig_out is constant 0 and no signature register exists.

Decomposition:
- Package mips_run_pkg holds:
  - the state enum (IDLE/RST/RUN/DONE);
  - status codes ST_NONE=0, ST_HALT=1, ST_TIMEOUT=2;
  - the signature rotate-xor function.
- One sub-module, mips_halt_det, contains the last-PC register, the repeat counter and the halt pulse output. It has parameter HALT_REPEAT and a clear input.

Test Plan:
- Reset release then start; retire with PCs 0x3000, 0x3004, 0x3008, then 0x300c ×4 → cpu_reset low exactly 1 cycle after start; status=1; instr_cnt=7; done=1.
- MAX_CYCLES=10, no retires → timeout after 10 RUN cycles; status=2; cycle_cnt=9 frozen; cpu_reset returns to 1.
- Halt repeat completes on the cycle with cycle_cnt=MAX_CYCLES-1 → status=1, not timeout.
- NUM_RUNS=3, each run halting → three RST phases of RST_CYCLES each; run_idx goes 0,1,2; counters cleared between runs; done only after the third run.
- reset pulled low mid-RUN with instr_cnt=5 → same cycle: cpu_reset=1, all counters 0, IDLE; start is needed to resume.
- With MIPS_RUN_SIG_EN, retires 0x3000 then 0x3004 → sig_out=0x3000, then 0x00006000^0x3004=0x5004.
